// File: rtl/ppu_pkg.sv
// Shared types for the ppu and its request arbiter.
//   operation_e / OP_BITS : ppu operation encoding
//   ppu_req_t             : one request bundle (op + three operands)
//   tag_width()           : bits needed to name one of num_req requesters
// Operand width defaults to the WORD macro (32 when not defined externally).
`ifndef WORD
`define WORD 32
`endif

package ppu_pkg;

  localparam int unsigned OP_BITS = 3;

  typedef enum logic [OP_BITS-1:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpMul  = 3'd2,
    OpMac  = 3'd3,
    OpRelu = 3'd4,
    OpMax  = 3'd5,
    OpMin  = 3'd6,
    OpPass = 3'd7
  } operation_e;

  typedef struct packed {
    operation_e        op;
    logic [`WORD-1:0]  operand1;
    logic [`WORD-1:0]  operand2;
    logic [`WORD-1:0]  operand3;
  } ppu_req_t;

  function automatic int unsigned tag_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/ppu_arb_tag_fifo.sv
// In-order tag FIFO holding the requester id of every op in flight in the ppu.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/tag_i : write a tag (ignored when full)
//   pop_i        : drop the head tag (ignored when empty)
//   full_o, empty_o, count_o, head_o : status and head entry
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module ppu_arb_tag_fifo #(
  parameter int unsigned TW    = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [TW-1:0]            tag_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [TW-1:0]            head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [TW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_en) - CW'(pop_en);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= tag_i;
    end
  end

endmodule

// File: rtl/ppu_arbiter.sv
// Round-robin arbiter sharing one ppu between NUM_REQ valid/ready requesters.
// At most one op is issued per cycle; the winner's id is queued as a tag and
// each ppu result is routed back to the requester at the head of that queue.
//   req_*         : per-requester valid/ready request ports (flattened vectors)
//   rsp_valid_o   : one-hot result strobe, rsp_result_o shared
//   ppu_*_o/_i    : registered issue port to the ppu and its result return
//   busy_o        : ops in flight; err_o sticky on a result with nothing in flight
// Build option PPU_ARB_PERF_EN adds perf_grant_o (32-bit grant count per
// requester) and perf_stall_o (cycles with a request pending while full).
module ppu_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned WORD    = `WORD,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*OP_BITS-1:0] req_op_i,
  input  logic [NUM_REQ*WORD-1:0]   req_operand1_i,
  input  logic [NUM_REQ*WORD-1:0]   req_operand2_i,
  input  logic [NUM_REQ*WORD-1:0]   req_operand3_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [WORD-1:0]           rsp_result_o,
  output logic                      ppu_valid_o,
  output logic [OP_BITS-1:0]        ppu_op_o,
  output logic [WORD-1:0]           ppu_operand1_o,
  output logic [WORD-1:0]           ppu_operand2_o,
  output logic [WORD-1:0]           ppu_operand3_o,
  input  logic [WORD-1:0]           ppu_result_i,
  input  logic                      ppu_valid_i,
`ifdef PPU_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]     perf_grant_o,
  output logic [31:0]               perf_stall_o,
`endif
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned TW = tag_width(NUM_REQ);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Requester index k positions after base, wrapping mod NUM_REQ.
  function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int unsigned k);
    int unsigned s;
    s = (32'(base) + 32'd1 + k) % NUM_REQ;
    return TW'(s);
  endfunction

  logic [TW-1:0]      ptr_q, ptr_d;
  logic               ppu_valid_q, ppu_valid_d;
  operation_e         ppu_op_q, ppu_op_d;
  logic [WORD-1:0]    opnd1_q, opnd1_d, opnd2_q, opnd2_d, opnd3_q, opnd3_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WORD-1:0]    rsp_result_q, rsp_result_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      grant_idx;
  logic [TW-1:0]      idx;
  logic               grant_any;
  logic               handshake;
  logic               pop;

  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [TW-1:0]      fifo_head;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = rr_idx(ptr_q, k);
      if (!grant_any && req_valid_i[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // No bypass on a same-cycle pop: a full FIFO blocks issue even if it drains now.
  assign req_ready_o = grant & {NUM_REQ{~fifo_full}};
  assign handshake   = grant_any & ~fifo_full;
  assign pop         = ppu_valid_i & ~fifo_empty;

  always_comb begin
    ptr_d        = ptr_q;
    ppu_valid_d  = handshake;
    ppu_op_d     = ppu_op_q;
    opnd1_d      = opnd1_q;
    opnd2_d      = opnd2_q;
    opnd3_d      = opnd3_q;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    err_d        = err_q | (ppu_valid_i & fifo_empty);
    if (handshake) begin
      ptr_d    = grant_idx;
      ppu_op_d = operation_e'(req_op_i[32'(grant_idx)*OP_BITS +: OP_BITS]);
      opnd1_d  = req_operand1_i[32'(grant_idx)*WORD +: WORD];
      opnd2_d  = req_operand2_i[32'(grant_idx)*WORD +: WORD];
      opnd3_d  = req_operand3_i[32'(grant_idx)*WORD +: WORD];
    end
    if (pop) begin
      rsp_valid_d[fifo_head] = 1'b1;
      rsp_result_d           = ppu_result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= TW'(NUM_REQ - 1);
      ppu_valid_q  <= 1'b0;
      ppu_op_q     <= OpAdd;
      opnd1_q      <= '0;
      opnd2_q      <= '0;
      opnd3_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      ppu_valid_q  <= ppu_valid_d;
      ppu_op_q     <= ppu_op_d;
      opnd1_q      <= opnd1_d;
      opnd2_q      <= opnd2_d;
      opnd3_q      <= opnd3_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      err_q        <= err_d;
    end
  end

  ppu_arb_tag_fifo #(
    .TW    (TW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .tag_i   (grant_idx),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign ppu_valid_o    = ppu_valid_q;
  assign ppu_op_o       = ppu_op_q;
  assign ppu_operand1_o = opnd1_q;
  assign ppu_operand2_o = opnd2_q;
  assign ppu_operand3_o = opnd3_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = rsp_result_q;
  assign busy_o         = (fifo_count != '0);
  assign err_o          = err_q;

`ifdef PPU_ARB_PERF_EN
  logic [31:0] perf_grant_q [NUM_REQ];
  logic [31:0] perf_grant_d [NUM_REQ];
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      perf_grant_d[i] = perf_grant_q[i] + 32'(req_ready_o[i] & req_valid_i[i]);
    end
    perf_stall_d = perf_stall_q + 32'((|req_valid_i) & fifo_full);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) perf_grant_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) perf_grant_q[i] <= perf_grant_d[i];
      perf_stall_q <= perf_stall_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
    assign perf_grant_o[g*32 +: 32] = perf_grant_q[g];
  end
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ppu_arbiter.sv
// Bench for ppu_arbiter with a stub ppu: fixed 3-cycle latency, result = operand1 + 1.
// The stub can be frozen (hold) and can emit a spurious result strobe (spur).
module tb_ppu_arbiter;
  import ppu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;
  localparam int unsigned D = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [N-1:0]         req_valid_i, req_ready_o, rsp_valid_o;
  logic [N*OP_BITS-1:0] req_op_i;
  logic [N*W-1:0]       req_operand1_i, req_operand2_i, req_operand3_i;
  logic [W-1:0]         rsp_result_o, ppu_operand1_o, ppu_operand2_o, ppu_operand3_o;
  logic [OP_BITS-1:0]   ppu_op_o;
  logic                 ppu_valid_o, ppu_valid_i, busy_o, err_o;
  logic [W-1:0]         ppu_result_i;
`ifdef PPU_ARB_PERF_EN
  logic [N*32-1:0]      perf_grant_o;
  logic [31:0]          perf_stall_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  ppu_arbiter #(.WORD(W), .NUM_REQ(N), .DEPTH(D)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_operand1_i (req_operand1_i),
    .req_operand2_i (req_operand2_i),
    .req_operand3_i (req_operand3_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_result_o   (rsp_result_o),
    .ppu_valid_o    (ppu_valid_o),
    .ppu_op_o       (ppu_op_o),
    .ppu_operand1_o (ppu_operand1_o),
    .ppu_operand2_o (ppu_operand2_o),
    .ppu_operand3_o (ppu_operand3_o),
    .ppu_result_i   (ppu_result_i),
    .ppu_valid_i    (ppu_valid_i),
`ifdef PPU_ARB_PERF_EN
    .perf_grant_o   (perf_grant_o),
    .perf_stall_o   (perf_stall_o),
`endif
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // ---------------- stub ppu ----------------
  typedef struct {
    logic [W-1:0] res;
    int           due;
  } stub_t;

  stub_t        stub_q[$];
  int           cyc;
  logic         stub_valid = 1'b0;
  logic [W-1:0] stub_result = '0;
  logic         hold = 1'b0;
  logic         spur = 1'b0;

  assign ppu_valid_i  = stub_valid | spur;
  assign ppu_result_i = stub_result;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        stub_q.delete();
        cyc = 0;
        stub_valid  <= 1'b0;
        stub_result <= '0;
      end else begin
        if (stub_valid) void'(stub_q.pop_front());
        if (ppu_valid_o) stub_q.push_back('{res: ppu_operand1_o + 32'd1, due: cyc + 3});
        cyc = cyc + 1;
        if (!hold && stub_q.size() > 0 && stub_q[0].due <= cyc) begin
          stub_valid  <= 1'b1;
          stub_result <= stub_q[0].res;
        end else begin
          stub_valid <= 1'b0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  int           rsp_id_q[$];
  logic [W-1:0] rsp_res_q[$];
  int           rsp_bad = 0;

  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o != '0) begin
      if (!$onehot(rsp_valid_o)) rsp_bad++;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid_o[i]) begin
          rsp_id_q.push_back(i);
          rsp_res_q.push_back(rsp_result_o);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [W-1:0] a);
    req_operand1_i[i*W +: W] = a;
    req_operand2_i[i*W +: W] = ~a;
    req_operand3_i[i*W +: W] = a ^ 32'h5a5a;
    req_op_i[i*OP_BITS +: OP_BITS] = OP_BITS'(i + 1);
  endtask

  task automatic apply_reset;
    req_valid_i = '0;
    hold = 1'b0;
    spur = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    rsp_id_q.delete();
    rsp_res_q.delete();
    rsp_bad = 0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk_i);
      if (!busy_o && stub_q.size() == 0 && !stub_valid) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    apply_reset();
    @(negedge clk_i);
    tests_run++; if (rsp_valid_o !== 4'b0000 || rsp_result_o !== 32'h0) begin tests_failed++;
      $display("FAIL reset_rsp: got %b/%h expected 0000/0", rsp_valid_o, rsp_result_o); end
    tests_run++; if (ppu_valid_o !== 1'b0 || ppu_op_o !== 3'd0) begin tests_failed++;
      $display("FAIL reset_ppu: got v=%b op=%0d expected 0/0", ppu_valid_o, ppu_op_o); end
    tests_run++; if ({ppu_operand1_o, ppu_operand2_o, ppu_operand3_o} !== 96'h0) begin
      tests_failed++; $display("FAIL reset_operands: got %h %h %h expected 0", ppu_operand1_o,
      ppu_operand2_o, ppu_operand3_o); end
    tests_run++; if (busy_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_status: got busy=%b err=%b rdy=%b expected 0",
      busy_o, err_o, req_ready_o); end
  endtask

  task automatic test_single;
    apply_reset();
    @(posedge clk_i); #1;
    set_req(1, 32'h10);
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    tests_run++; if (req_ready_o !== 4'b0010) begin tests_failed++;
      $display("FAIL single_ready: got %b expected 0010", req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    tests_run++; if (ppu_valid_o !== 1'b1 || ppu_operand1_o !== 32'h10 || ppu_op_o !== 3'd2 ||
      ppu_operand2_o !== 32'hffffffef || ppu_operand3_o !== 32'h5a4a) begin tests_failed++;
      $display("FAIL single_issue: got v=%b op=%0d a=%h b=%h c=%h expected 1/2/10/ffffffef/5a4a",
      ppu_valid_o, ppu_op_o, ppu_operand1_o, ppu_operand2_o, ppu_operand3_o); end
    @(negedge clk_i);
    tests_run++; if (ppu_valid_o !== 1'b0 || ppu_operand1_o !== 32'h10) begin tests_failed++;
      $display("FAIL single_hold: got v=%b a=%h expected 0/10", ppu_valid_o, ppu_operand1_o); end
    repeat (2) @(negedge clk_i);
    tests_run++; if (rsp_valid_o !== 4'b0000 || busy_o !== 1'b1) begin tests_failed++;
      $display("FAIL single_early: got rsp=%b busy=%b expected 0000/1", rsp_valid_o, busy_o); end
    @(negedge clk_i);
    tests_run++; if (rsp_valid_o !== 4'b0010 || rsp_result_o !== 32'h11) begin tests_failed++;
      $display("FAIL single_rsp: got %b/%h expected 0010/11", rsp_valid_o, rsp_result_o); end
    @(negedge clk_i);
    tests_run++; if (rsp_valid_o !== 4'b0000 || rsp_result_o !== 32'h11 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL single_after: got %b/%h busy=%b expected 0000/11/0",
      rsp_valid_o, rsp_result_o, busy_o); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp;
    bit ok;
    apply_reset();
    @(posedge clk_i); #1;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + i);
    req_valid_i = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      exp = N'(1) << (k % 4);
      tests_run++; if (req_ready_o !== exp) begin tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready_o, exp); end
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    wait_idle(40, ok);
    tests_run++; if (!ok || rsp_id_q.size() != 8 || rsp_bad != 0) begin tests_failed++;
      $display("FAIL rr_drain: got idle=%0d rsps=%0d bad=%0d expected 1/8/0", ok,
      rsp_id_q.size(), rsp_bad); end
    for (int k = 0; k < 8 && k < rsp_id_q.size(); k++) begin
      tests_run++; if (rsp_id_q[k] != k % 4 || rsp_res_q[k] !== 32'h101 + 32'(k % 4)) begin
        tests_failed++; $display("FAIL rr_rsp[%0d]: got id=%0d res=%h expected id=%0d res=%h", k,
        rsp_id_q[k], rsp_res_q[k], k % 4, 32'h101 + 32'(k % 4)); end
    end
  endtask

  task automatic test_full;
    logic [N-1:0] exp;
    bit ok;
    apply_reset();
    @(posedge clk_i); #1;
    hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h200 + i);
    req_valid_i = '1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_i);
      if (k < 8)       exp = N'(1) << (k % 4);
      else if (k == 14) exp = 4'b0001;
      else if (k == 15) exp = 4'b0010;
      else             exp = 4'b0000;
      tests_run++; if (req_ready_o !== exp) begin tests_failed++;
        $display("FAIL full_ready[%0d]: got %b expected %b", k, req_ready_o, exp); end
      if (k == 10) begin
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++;
          $display("FAIL full_busy: got %b expected 1", busy_o); end
      end
      @(posedge clk_i); #1;
      if (k == 11) hold = 1'b0;
    end
    req_valid_i = '0;
    @(negedge clk_i);
`ifdef PPU_ARB_PERF_EN
    tests_run++; if (perf_stall_o !== 32'd6) begin tests_failed++;
      $display("FAIL perf_stall: got %0d expected 6", perf_stall_o); end
    tests_run++; if (perf_grant_o !== {32'd2, 32'd2, 32'd3, 32'd3}) begin tests_failed++;
      $display("FAIL perf_grant: got %h expected 2/2/3/3", perf_grant_o); end
`endif
    wait_idle(60, ok);
    tests_run++; if (!ok || rsp_id_q.size() != 10 || rsp_bad != 0) begin tests_failed++;
      $display("FAIL full_drain: got idle=%0d rsps=%0d bad=%0d expected 1/10/0", ok,
      rsp_id_q.size(), rsp_bad); end
    for (int k = 0; k < 10 && k < rsp_id_q.size(); k++) begin
      tests_run++; if (rsp_id_q[k] != k % 4 || rsp_res_q[k] !== 32'h201 + 32'(k % 4)) begin
        tests_failed++; $display("FAIL full_rsp[%0d]: got id=%0d res=%h expected id=%0d res=%h",
        k, rsp_id_q[k], rsp_res_q[k], k % 4, 32'h201 + 32'(k % 4)); end
    end
  endtask

  task automatic test_err;
    apply_reset();
    @(posedge clk_i); #1;
    spur = 1'b1;
    @(negedge clk_i);
    tests_run++; if (err_o !== 1'b0) begin tests_failed++;
      $display("FAIL err_early: got %b expected 0", err_o); end
    @(posedge clk_i); #1;
    spur = 1'b0;
    @(negedge clk_i);
    tests_run++; if (err_o !== 1'b1 || rsp_valid_o !== 4'b0000) begin tests_failed++;
      $display("FAIL err_set: got err=%b rsp=%b expected 1/0000", err_o, rsp_valid_o); end
    repeat (5) @(negedge clk_i);
    tests_run++; if (err_o !== 1'b1 || busy_o !== 1'b0 || rsp_id_q.size() != 0) begin
      tests_failed++; $display("FAIL err_sticky: got err=%b busy=%b rsps=%0d expected 1/0/0",
      err_o, busy_o, rsp_id_q.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    apply_reset();
    @(posedge clk_i); #1;
    hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h300 + i);
    req_valid_i = '1;
    repeat (5) begin @(posedge clk_i); #1; end
    req_valid_i = '0;
    #1;
    tests_run++; if (ppu_valid_o !== 1'b1 || busy_o !== 1'b1) begin tests_failed++;
      $display("FAIL mid_before: got v=%b busy=%b expected 1/1", ppu_valid_o, busy_o); end
    #1;
    rst_i = 1'b1;
    #1;
    tests_run++; if (ppu_valid_o !== 1'b0 || ppu_operand1_o !== 32'h0 || ppu_op_o !== 3'd0 ||
      busy_o !== 1'b0 || err_o !== 1'b0 || rsp_valid_o !== 4'b0000 || req_ready_o !== 4'b0000)
      begin tests_failed++; $display("FAIL mid_async: got v=%b a=%h op=%0d busy=%b err=%b rsp=%b",
      ppu_valid_o, ppu_operand1_o, ppu_op_o, busy_o, err_o, rsp_valid_o); end
    hold = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    rsp_id_q.delete();
    rsp_res_q.delete();
    @(posedge clk_i); #1;
    set_req(0, 32'h400);
    set_req(2, 32'h420);
    req_valid_i = 4'b0101;
    @(negedge clk_i);
    tests_run++; if (req_ready_o !== 4'b0001 || busy_o !== 1'b0) begin tests_failed++;
      $display("FAIL mid_first: got rdy=%b busy=%b expected 0001/0", req_ready_o, busy_o); end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    wait_idle(30, ok);
    tests_run++; if (!ok || rsp_id_q.size() != 1) begin tests_failed++;
      $display("FAIL mid_drain: got idle=%0d rsps=%0d expected 1/1", ok, rsp_id_q.size()); end
    else begin
      tests_run++; if (rsp_id_q[0] != 0 || rsp_res_q[0] !== 32'h401) begin tests_failed++;
        $display("FAIL mid_rsp: got id=%0d res=%h expected 0/401", rsp_id_q[0], rsp_res_q[0]); end
    end
  endtask

  task automatic test_priority;
    logic [N-1:0] exp;
    int           exp_id [5];
    bit           ok;
    exp_id = '{0, 2, 0, 2, 0};
    apply_reset();
    @(posedge clk_i); #1;
    set_req(0, 32'h500);
    set_req(2, 32'h520);
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    tests_run++; if (req_ready_o !== 4'b0001) begin tests_failed++;
      $display("FAIL prio_first: got %b expected 0001", req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      exp = (k % 2 == 0) ? 4'b0100 : 4'b0001;
      tests_run++; if (req_ready_o !== exp) begin tests_failed++;
        $display("FAIL prio_grant[%0d]: got %b expected %b", k, req_ready_o, exp); end
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    wait_idle(40, ok);
    tests_run++; if (!ok || rsp_id_q.size() != 5) begin tests_failed++;
      $display("FAIL prio_drain: got idle=%0d rsps=%0d expected 1/5", ok, rsp_id_q.size()); end
    for (int k = 0; k < 5 && k < rsp_id_q.size(); k++) begin
      tests_run++; if (rsp_id_q[k] != exp_id[k] ||
        rsp_res_q[k] !== ((exp_id[k] == 0) ? 32'h501 : 32'h521)) begin tests_failed++;
        $display("FAIL prio_rsp[%0d]: got id=%0d res=%h expected id=%0d", k, rsp_id_q[k],
        rsp_res_q[k], exp_id[k]); end
    end
  endtask

  initial begin
    req_valid_i    = '0;
    req_op_i       = '0;
    req_operand1_i = '0;
    req_operand2_i = '0;
    req_operand3_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_err();
    test_reset_mid();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
